// File: rtl/rr_reg_arbiter_if.sv
// Bundle of requester-side and arbiter-side signals for the shared-register round-robin arbiter.
interface rr_reg_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = 2
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ-1:0]       wr_en;
   logic [N_REQ*WIDTH-1:0] d_in;
   logic [N_REQ-1:0]       gnt;
   logic [ID_W-1:0]        owner;
   logic                   busy;
   logic [WIDTH-1:0]       q;
   logic                   q_valid;

   modport master (
      output req, wr_en, d_in,
      input  gnt, owner, busy, q, q_valid
   );

   modport slave (
      input  req, wr_en, d_in,
      output gnt, owner, busy, q, q_valid
   );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a shared WIDTH-bit register.
// Owners are bounded to MAX_HOLD consecutive cycles while others wait; handover has no idle bubble.
module rr_reg_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 8,
   parameter int ID_W     = 2,
   parameter int MAX_HOLD = 4
) (
   input logic            clk,
   input logic            reset,
   rr_reg_arbiter_if.slave bus
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   typedef enum logic {IDLE, OWN} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              valid_q, valid_d;

   logic [ID_W-1:0]   owner_inc;
   logic [N_REQ-1:0]  others;
   logic [ID_W:0]     pick_idle;
   logic [ID_W:0]     pick_own;
   logic              release_own;

   // First set bit of vec at or after start, wrapping; MSB of the result flags a hit.
   function automatic logic [ID_W:0] rr_search(input logic [N_REQ-1:0] vec,
                                               input logic [ID_W-1:0]  start);
      logic [ID_W:0] result;
      int            idx;
      result = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % N_REQ;
         if (vec[idx]) begin
            result = {1'b1, ID_W'(idx)};
         end
      end
      return result;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         hold_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // A release with no other pending requester can only mean the owner dropped, so the grant goes idle.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      hold_d      = hold_q;
      owner_inc   = (int'(owner_q) == N_REQ - 1) ? '0 : owner_q + ID_W'(1);
      others      = bus.req & ~gnt_q;
      pick_idle   = rr_search(bus.req, ptr_q);
      pick_own    = rr_search(others, owner_inc);
      release_own = !bus.req[owner_q] || ((hold_q == HOLD_W'(MAX_HOLD)) && (|others));
      case (state_q)
         IDLE: begin
            if (pick_idle[ID_W]) begin
               state_d = OWN;
               owner_d = pick_idle[ID_W-1:0];
               gnt_d   = N_REQ'(1) << pick_idle[ID_W-1:0];
               hold_d  = HOLD_W'(1);
            end
         end
         OWN: begin
            if (release_own) begin
               ptr_d = owner_inc;
               if (pick_own[ID_W]) begin
                  owner_d = pick_own[ID_W-1:0];
                  gnt_d   = N_REQ'(1) << pick_own[ID_W-1:0];
                  hold_d  = HOLD_W'(1);
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  hold_d  = '0;
               end
            end else if (hold_q < HOLD_W'(MAX_HOLD)) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Writes are qualified by the registered grant, so the outgoing owner's last cycle still lands.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_q[i] && bus.wr_en[i]) begin
            data_d  = bus.d_in[i*WIDTH +: WIDTH];
            valid_d = 1'b1;
         end
      end
   end

   always_comb begin
      bus.gnt     = gnt_q;
      bus.owner   = owner_q;
      bus.busy    = |gnt_q;
      bus.q       = data_q;
      bus.q_valid = valid_q;
   end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed self-checking bench for rr_reg_arbiter: reset, rotation, write ownership, handover and lone-owner cases.
module tb_rr_reg_arbiter;

   localparam int N_REQ    = 4;
   localparam int WIDTH    = 8;
   localparam int ID_W     = 2;
   localparam int MAX_HOLD = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   rr_reg_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

   rr_reg_arbiter #(
      .N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one input vector, then sample 1 time unit after the last of `cycles` rising edges.
   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w, input logic [31:0] d, input int cycles);
      bus.req   = r;
      bus.wr_en = w;
      bus.d_in  = d;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      bus.req   = 4'b1111;
      bus.wr_en = '0;
      bus.d_in  = '0;

      applyStimulus(4'b1111, 4'b0000, 32'h0, 2);
      checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
      checkOutput("rst_busy", 32'(bus.busy), 32'h0);
      checkOutput("rst_q", 32'(bus.q), 32'h0);
      checkOutput("rst_qv", 32'(bus.q_valid), 32'h0);

      reset = 1'b0;
      applyStimulus(4'b0100, 4'b0000, 32'h0, 1);
      checkOutput("first_gnt", 32'(bus.gnt), 32'h4);
      checkOutput("first_owner", 32'(bus.owner), 32'd2);
      checkOutput("first_busy", 32'(bus.busy), 32'h1);

      // Park the pointer back at 0: idle, grant 3, release 3.
      applyStimulus(4'b0000, 4'b0000, 32'h0, 1);
      checkOutput("drop2_gnt", 32'(bus.gnt), 32'h0);
      applyStimulus(4'b1000, 4'b0000, 32'h0, 1);
      checkOutput("grant3_gnt", 32'(bus.gnt), 32'h8);
      applyStimulus(4'b0000, 4'b0000, 32'h0, 1);
      checkOutput("drop3_busy", 32'(bus.busy), 32'h0);

      for (int k = 1; k <= 20; k++) begin
         applyStimulus(4'b1111, 4'b0000, 32'h0, 1);
         checkOutput($sformatf("rot%0d_gnt", k), 32'(bus.gnt), 32'(4'b0001 << (((k - 1) / 4) % 4)));
         checkOutput($sformatf("rot%0d_busy", k), 32'(bus.busy), 32'h1);
      end

      applyStimulus(4'b0010, 4'b0000, 32'h0, 1);
      checkOutput("own1_gnt", 32'(bus.gnt), 32'h2);
      applyStimulus(4'b0010, 4'b0010, 32'h3C77A511, 1);
      checkOutput("wr1_q", 32'(bus.q), 32'hA5);
      checkOutput("wr1_qv", 32'(bus.q_valid), 32'h1);
      applyStimulus(4'b0010, 4'b1000, 32'h3C77A511, 1);
      checkOutput("wr3_ignored_q", 32'(bus.q), 32'hA5);
      checkOutput("wr3_owner", 32'(bus.owner), 32'd1);

      applyStimulus(4'b0001, 4'b0000, 32'h0, 1);
      checkOutput("own0_gnt", 32'(bus.gnt), 32'h1);
      applyStimulus(4'b1001, 4'b0000, 32'h0, 1);
      checkOutput("own0_hold_gnt", 32'(bus.gnt), 32'h1);
      applyStimulus(4'b1000, 4'b0001, 32'h0000005A, 1);
      checkOutput("handover_gnt", 32'(bus.gnt), 32'h8);
      checkOutput("handover_busy", 32'(bus.busy), 32'h1);
      checkOutput("handover_owner", 32'(bus.owner), 32'd3);
      checkOutput("lastcycle_wr_q", 32'(bus.q), 32'h5A);

      applyStimulus(4'b0100, 4'b0000, 32'h0, 1);
      checkOutput("lone_start_gnt", 32'(bus.gnt), 32'h4);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(4'b0100, 4'b1011, 32'hFFFFFFFF, 1);
         checkOutput($sformatf("lone%0d_gnt", k), 32'(bus.gnt), 32'h4);
      end
      checkOutput("nonowner_wr_q", 32'(bus.q), 32'h5A);
      applyStimulus(4'b0000, 4'b0000, 32'h0, 1);
      checkOutput("lone_drop_gnt", 32'(bus.gnt), 32'h0);
      checkOutput("lone_drop_busy", 32'(bus.busy), 32'h0);

      applyStimulus(4'b0010, 4'b0000, 32'h0, 1);
      checkOutput("ptr3_pick_gnt", 32'(bus.gnt), 32'h2);
      applyStimulus(4'b0010, 4'b0010, 32'h0000C300, 1);
      checkOutput("wrC3_q", 32'(bus.q), 32'hC3);
      applyStimulus(4'b0010, 4'b0000, 32'h0, 1);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_gnt", 32'(bus.gnt), 32'h0);
      checkOutput("async_rst_busy", 32'(bus.busy), 32'h0);
      checkOutput("async_rst_q", 32'(bus.q), 32'h0);
      checkOutput("async_rst_qv", 32'(bus.q_valid), 32'h0);
      #1;
      reset = 1'b0;
      applyStimulus(4'b1111, 4'b0000, 32'h0, 1);
      checkOutput("post_rst_gnt", 32'(bus.gnt), 32'h1);
      checkOutput("post_rst_owner", 32'(bus.owner), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
